// File: rtl/blink_period_meter.sv
// Measures the high and low time of an external blinking level in clk cycles.
// Publishes each completed high+low pair with a one-cycle pulse and flags lock/stall.
module blink_period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blink_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] StallCnt   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StAcquire,
        StArm,
        StMeasHigh,
        StMeasLow,
        StStall
    } state_e;

    state_e state_q, state_d;

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hold_high_q, hold_high_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;
    logic             stuck_q, stuck_d;

    logic sync_level;
    logic edge_ev, rise_ev, fall_ev;

    assign sync_level = sync2_q;
    assign edge_ev    = sync_level ^ prev_q;
    assign rise_ev    = edge_ev & sync_level;
    assign fall_ev    = edge_ev & ~sync_level;

    // run_cnt counts the edge cycle as 1, so at an edge it holds the finished phase length
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (edge_ev) begin
            run_cnt_d = CNT_W'(1);
        end else if (run_cnt_q != TimeoutCnt) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_high_d = hold_high_q;
        high_d      = high_q;
        low_d       = low_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        stalled_d   = stalled_q;
        stuck_d     = stuck_q;

        unique case (state_q)
            StAcquire: begin
                if (fall_ev) state_d = StArm;
            end
            StArm: begin
                if (rise_ev) state_d = StMeasHigh;
            end
            StMeasHigh: begin
                if (fall_ev) begin
                    hold_high_d = run_cnt_q;
                    state_d     = StMeasLow;
                end
            end
            StMeasLow: begin
                if (rise_ev) begin
                    high_d   = hold_high_q;
                    low_d    = run_cnt_q;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                    state_d  = StMeasHigh;
                end
            end
            StStall: begin
                if (rise_ev) begin
                    stalled_d = 1'b0;
                    state_d   = StMeasHigh;
                end else if (fall_ev) begin
                    stalled_d = 1'b0;
                    state_d   = StArm;
                end
            end
            default: state_d = StAcquire;
        endcase

        // An edge in the timeout cycle wins, so only a quiet cycle can enter the stall
        if (state_q != StStall && !edge_ev && run_cnt_q == StallCnt) begin
            state_d   = StStall;
            stalled_d = 1'b1;
            stuck_d   = sync_level;
            locked_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            run_cnt_q   <= CNT_W'(1);
            state_q     <= StAcquire;
            hold_high_q <= '0;
            high_q      <= '0;
            low_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            stalled_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            sync1_q     <= blink_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync_level;
            run_cnt_q   <= run_cnt_d;
            state_q     <= state_d;
            hold_high_q <= hold_high_d;
            high_q      <= high_d;
            low_q       <= low_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            stalled_q   <= stalled_d;
            stuck_q     <= stuck_d;
        end
    end

    assign high_cycles  = high_q;
    assign low_cycles   = low_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign stalled      = stalled_q;
    assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter: table of blink periods with expected pulses,
// plus hand sequences for reset, stall, resume and the timeout boundary.
module tb_blink_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             blink_in;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic             period_valid;
    logic             locked;
    logic             stalled;
    logic             stuck_level;

    blink_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .blink_in    (blink_in),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .period_valid(period_valid),
        .locked      (locked),
        .stalled     (stalled),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log written only by this monitor; the main process reads it by index
    int q_cyc[$];
    int q_hi[$];
    int q_lo[$];
    int q_lock[$];
    int stall_seen = 0;

    always @(negedge clk) begin
        if (rst === 1'b0 && period_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_hi.push_back(int'(high_cycles));
            q_lo.push_back(int'(low_cycles));
            q_lock.push_back(int'(locked));
        end
        if (rst === 1'b0 && stalled === 1'b1) stall_seen++;
    end

    typedef struct {
        int hi;
        int lo;
        bit pulse;
        int exp_hi;
        int exp_lo;
        bit chk_gap;
    } rec_t;

    rec_t tbl[21];

    int checks    = 0;
    int failures  = 0;
    int rd_idx    = 0;
    int exp_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        longint outs;
        outs = longint'({high_cycles, low_cycles, period_valid, locked, stalled, stuck_level});
        chk(name, outs, 0);
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            blink_in = lvl;
        end
    endtask

    task automatic run_recs(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            drive(1'b1, tbl[i].hi);
            drive(1'b0, tbl[i].lo);
        end
    endtask

    task automatic check_recs(input int a, input int b);
        int prev_cyc;
        bit have_prev;
        have_prev = 1'b0;
        prev_cyc  = 0;
        for (int i = a; i <= b; i++) begin
            if (tbl[i].pulse) begin
                exp_total++;
                if (rd_idx >= q_hi.size()) begin
                    chk($sformatf("rec%0d_pulse_present", i), 0, 1);
                    have_prev = 1'b0;
                end else begin
                    chk($sformatf("rec%0d_high", i), q_hi[rd_idx], tbl[i].exp_hi);
                    chk($sformatf("rec%0d_low", i), q_lo[rd_idx], tbl[i].exp_lo);
                    chk($sformatf("rec%0d_locked", i), q_lock[rd_idx], 1);
                    if (tbl[i].chk_gap && have_prev)
                        chk($sformatf("rec%0d_gap", i), q_cyc[rd_idx] - prev_cyc,
                            tbl[i].hi + tbl[i].lo);
                    prev_cyc  = q_cyc[rd_idx];
                    have_prev = 1'b1;
                    rd_idx++;
                end
            end
        end
        chk($sformatf("pulse_count_to_rec%0d", b), q_hi.size(), exp_total);
        rd_idx = q_hi.size();
    endtask

    initial begin
        int stall_base;

        // {hi, lo, pulse expected, exp high, exp low, check spacing}
        tbl[0]  = '{10, 6, 1'b0, 0, 0, 1'b0};  // rise ignored while acquiring
        tbl[1]  = '{10, 6, 1'b1, 10, 6, 1'b0};
        tbl[2]  = '{10, 6, 1'b1, 10, 6, 1'b1};
        tbl[3]  = '{10, 6, 1'b1, 10, 6, 1'b1};
        tbl[4]  = '{10, 3, 1'b1, 10, 3, 1'b1};  // rate switches mid-low
        tbl[5]  = '{3, 3, 1'b1, 3, 3, 1'b1};
        tbl[6]  = '{3, 3, 1'b1, 3, 3, 1'b1};
        tbl[7]  = '{3, 3, 1'b1, 3, 3, 1'b1};
        tbl[8]  = '{5, 4, 1'b1, 5, 4, 1'b0};    // first pair after stall resume
        for (int i = 9; i <= 14; i++) tbl[i] = '{1, 1, 1'b1, 1, 1, 1'b1};
        tbl[15] = '{10, 6, 1'b1, 10, 6, 1'b1};
        tbl[16] = '{10, 6, 1'b1, 10, 6, 1'b1};
        tbl[17] = '{10, 6, 1'b0, 0, 0, 1'b0};  // relock after reset
        tbl[18] = '{10, 6, 1'b1, 10, 6, 1'b0};
        tbl[19] = '{49, 7, 1'b1, 49, 7, 1'b1};  // longest phase that must not stall
        tbl[20] = '{1, 1, 1'b1, 1, 1, 1'b1};

        rst      = 1'b1;
        blink_in = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_zero($sformatf("reset_hold_%0d", i));
            blink_in = ~blink_in;
        end

        @(negedge clk);
        rst      = 1'b0;
        blink_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_valid_after_release_%0d", i), period_valid, 0);
            chk($sformatf("no_lock_after_release_%0d", i), locked, 0);
            blink_in = (i == 2) ? 1'b1 : 1'b0;
        end

        @(negedge clk);
        rst      = 1'b1;
        blink_in = 1'b0;
        @(negedge clk);
        chk_zero("rereset");
        rst = 1'b0;
        drive(1'b0, 3);

        run_recs(0, 7);

        // Hold high: closes the last 3/3 pair, then must stall
        @(negedge clk);
        blink_in = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (k == 2) chk("latency_early", period_valid, 0);
            if (k == 3) chk("latency_3clk", period_valid, 1);
            if (k == 51) begin
                chk("stall_not_early", stalled, 0);
                chk("locked_before_stall", locked, 1);
            end
            if (k == 52) begin
                chk("stall_set", stalled, 1);
                chk("stuck_level_high", stuck_level, 1);
                chk("locked_cleared_stall", locked, 0);
                chk("stall_hold_high", high_cycles, 3);
                chk("stall_hold_low", low_cycles, 3);
            end
        end
        @(posedge clk);
        check_recs(0, 7);

        drive(1'b0, 4);
        chk("stall_cleared", stalled, 0);
        chk("stuck_level_held", stuck_level, 1);
        chk("locked_after_resume", locked, 0);

        run_recs(8, 16);
        drive(1'b1, 10);
        drive(1'b0, 4);
        chk("locked_before_rst", locked, 1);
        @(posedge clk);
        check_recs(8, 16);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_in_meas_low");
        rst = 1'b0;
        drive(1'b0, 2);

        stall_base = stall_seen;
        run_recs(17, 20);
        drive(1'b1, 4);
        @(posedge clk);
        check_recs(17, 20);
        chk("no_stall_at_boundary", stall_seen - stall_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Input-side counterpart to the LED blink generator: samples an external blinking level and measures it.
- Measures, in clk cycles, the high time and the low time of each full period, and reports each completed high+low pair with a one-cycle valid pulse.
- Flags lock/stall so a bench or downstream logic can check a blinker's timing without a waveform viewer.

Parameters:
- CNT_W, 16, width of measured length outputs and internal run counter.
- TIMEOUT, 1000, cycles without an edge before the input is declared stalled. Legal range is 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- blink_in  input  1  asynchronous blinking level to measure
- high_cycles  output  CNT_W  length of last completed high phase
- low_cycles  output  CNT_W  length of last completed low phase
- period_valid  output  1  one-cycle pulse; high_cycles/low_cycles just updated
- locked  output  1  at least one full pair measured since reset/stall
- stalled  output  1  no edge for TIMEOUT cycles
- stuck_level  output  1  synchronized level at the time of stall

Behaviour:
- Reset: one clock with rst=1 clears all outputs to 0, both synchronizer flops to 0, prev_level to 0, run_cnt to 1, and state to ACQUIRE. rst has priority over every event, including mid-measurement.
- Synchronizer: 2 flops. sync_level = blink_in delayed 2 cycles. Both edges see equal delay, so measured lengths equal true input lengths.
- Edge event: sync_level != prev_level in a cycle. The event is rise if sync_level=1, fall otherwise. prev_level <= sync_level every cycle.
- run_cnt: number of cycles the current synchronized level has been present, counting the edge cycle as 1.
  - On an edge event, run_cnt <= 1.
  - Otherwise run_cnt increments, saturating at TIMEOUT.
  - At an edge event, the completed phase length is run_cnt's current value.
- States:
  - ACQUIRE: ignore rise; on fall -> ARM.
  - ARM: on rise -> MEAS_HIGH. The phase ending here is not published.
  - MEAS_HIGH: on fall, hold_high <= run_cnt -> MEAS_LOW.
  - MEAS_LOW: on rise, high_cycles <= hold_high, low_cycles <= run_cnt, period_valid <= 1 (next cycle only), locked <= 1 -> MEAS_HIGH.
  - STALL: rise -> MEAS_HIGH; fall -> ARM. Any edge clears stalled.
  - Any state except STALL: run_cnt == TIMEOUT-1 with no edge this cycle -> STALL next cycle, with stalled <= 1, stuck_level <= sync_level, locked <= 0.
- Stall outputs:
  - high_cycles/low_cycles hold their last published values through STALL.
  - stuck_level holds its value until the next stall or reset.
- period_valid latency: asserted in the cycle after the rise event that closes a low phase, i.e. 3 clocks after blink_in rises at the pin.
- Minimum input: 1-cycle high and 1-cycle low phases must be measured exactly, with no missed edges.
- Edge and timeout in the same cycle: the edge wins and no stall is entered.
- Inputs narrower than one clock period are undefined and not checked.

Test Plan:
- Reset: rst=1 for 4 cycles while blink_in toggles every cycle -> all outputs 0 throughout; no period_valid for at least 2 full periods after release.
- Steady blink, 10 high / 6 low repeating, TIMEOUT=50:
  - first period_valid once ACQUIRE->ARM->MEAS_HIGH->MEAS_LOW completes;
  - every pulse carries high_cycles=10, low_cycles=6;
  - pulses exactly 16 cycles apart; locked=1 from the first pulse.
- Rate change from 10/6 to 3/3 mid-stream -> each pulse reports that period's actual pair (e.g. 10/3 if the switch falls mid-low), then 3/3 every 6 cycles; no pulse lost or duplicated.
- Stall, TIMEOUT=50: after 3/3 lock, hold blink_in=1:
  - stalled=1, stuck_level=1, locked=0 exactly 50 cycles after the rise was synchronized;
  - high/low hold 3/3;
  - then 4 low / 5 high resumes -> next pulse high=5 low=4, stalled=0.
- Fastest input, 1 high / 1 low alternating -> pulse every 2 cycles with high_cycles=1, low_cycles=1; locked stays 1.
- Reset in MEAS_LOW with 10/6 running -> outputs 0 the cycle after rst; relock requires full fall, rise, fall, rise; first post-reset pulse reports 10/6.
